// File: rtl/axis_fifo_sync.sv
// axis_fifo_sync: single-clock AXI4-Stream FIFO, first-word-fall-through.
// Ports: aclk/aresetn, s_axis_* (in), m_axis_* (out), data_count, almost_full, drop_count.
module axis_fifo_sync #(
   parameter int AXIS_TDATA_WIDTH      = 32,
   parameter int ADDR_WIDTH            = 10,
   parameter int ALMOST_FULL_THRESHOLD = 2**ADDR_WIDTH - 16,
   parameter bit ALWAYS_READY          = 1'b0,
   parameter bit ALWAYS_VALID          = 1'b0
) (
   input  logic                        aclk,
   input  logic                        aresetn,
   output logic                        s_axis_tready,
   input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
   input  logic                        s_axis_tvalid,
   input  logic                        m_axis_tready,
   output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
   output logic                        m_axis_tvalid,
   output logic [ADDR_WIDTH:0]         data_count,
   output logic                        almost_full,
   output logic [15:0]                 drop_count
);

   localparam int              CW      = ADDR_WIDTH + 1;
   localparam int              DEPTH   = 2**ADDR_WIDTH;
   localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0]   AF_C    = CW'(ALMOST_FULL_THRESHOLD);

   logic [AXIS_TDATA_WIDTH-1:0] mem [DEPTH];

   logic [ADDR_WIDTH-1:0]       wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH-1:0]       rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]               count_q, count_d;
   logic [AXIS_TDATA_WIDTH-1:0] dout_q, dout_d;
   logic                        ovalid_q, ovalid_d;
   logic                        tready_q, tready_d;
   logic                        af_q, af_d;
   logic [15:0]                 drop_q, drop_d;

   logic          full;
   logic          s_ready;
   logic          wr_en;
   logic          rd_en;
   logic          load_out;
   logic          bypass;
   logic          mem_we;
   logic [CW-1:0] ram_cnt;

   assign full     = (count_q == DEPTH_C);
   // Legacy always-ready mode still shows not-ready while held in reset.
   assign s_ready  = ALWAYS_READY ? aresetn : tready_q;
   assign wr_en    = s_axis_tvalid & s_ready & ~full;
   assign rd_en    = ovalid_q & m_axis_tready;
   // Words sitting in the RAM behind the output register.
   assign ram_cnt  = count_q - CW'(ovalid_q);
   assign load_out = ~ovalid_q | rd_en;
   // Empty RAM and a free output slot: the incoming word skips the RAM.
   assign bypass   = load_out & wr_en & (ram_cnt == '0);
   assign mem_we   = wr_en & ~bypass;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      dout_d   = dout_q;
      ovalid_d = ovalid_q;
      drop_d   = drop_q;
      if (mem_we) begin
         wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
      end
      if (load_out) begin
         if (ram_cnt != '0) begin
            dout_d   = mem[rd_ptr_q];
            ovalid_d = 1'b1;
            rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
         end else if (wr_en) begin
            dout_d   = s_axis_tdata;
            ovalid_d = 1'b1;
         end else begin
            // Going empty clears the data so always-valid mode shows zero.
            dout_d   = '0;
            ovalid_d = 1'b0;
         end
      end
      count_d  = count_q + CW'(wr_en) - CW'(rd_en);
      tready_d = (count_d != DEPTH_C);
      af_d     = (count_d >= AF_C);
      // A read in the same cycle does not rescue a write arriving while full.
      if (ALWAYS_READY && s_axis_tvalid && full && (drop_q != 16'hFFFF)) begin
         drop_d = drop_q + 16'd1;
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         dout_q   <= '0;
         ovalid_q <= 1'b0;
         tready_q <= 1'b0;
         af_q     <= 1'b0;
         drop_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         dout_q   <= dout_d;
         ovalid_q <= ovalid_d;
         tready_q <= tready_d;
         af_q     <= af_d;
         drop_q   <= drop_d;
      end
   end

   // Storage contents are intentionally not reset.
   always_ff @(posedge aclk) begin
      if (mem_we) begin
         mem[wr_ptr_q] <= s_axis_tdata;
      end
   end

   assign s_axis_tready = s_ready;
   assign m_axis_tdata  = dout_q;
   assign m_axis_tvalid = ALWAYS_VALID ? 1'b1 : ovalid_q;
   assign data_count    = count_q;
   assign almost_full   = af_q;
   assign drop_count    = drop_q;

endmodule
